// File: rtl/lsu_stage_if.sv
// Bundles the EX-side handshake, the data-memory port and the writeback outputs of lsu_stage.
// The slave modport is the stage's view; master is the surrounding pipeline/memory.
interface lsu_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rd2;
    logic [4:0]  ex_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    modport slave (
        input  ex_valid, ex_opcode, ex_funct3, ex_alu_result, ex_rd2, ex_rd,
        input  mem_ack, mem_rdata,
        output ex_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_regwrite, wb_rd, wb_data, wb_exc
    );

    modport master (
        output ex_valid, ex_opcode, ex_funct3, ex_alu_result, ex_rd2, ex_rd,
        output mem_ack, mem_rdata,
        input  ex_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_regwrite, wb_rd, wb_data, wb_exc
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: one EX op per handshake, req/ack memory access with lane steering,
// load extension, misalignment/illegal-size/timeout reporting, one-cycle writeback pulse.
module lsu_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_stage_if.slave  bus
);
    localparam logic [0:0]  S_IDLE        = 1'b0;
    localparam logic [0:0]  S_REQ         = 1'b1;
    localparam logic [6:0]  OP_LOAD       = 7'b0000011;
    localparam logic [6:0]  OP_STORE      = 7'b0100011;
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(ACK_TIMEOUT);

    logic [0:0]  state_reg;
    logic [15:0] cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        we_reg;
    logic [1:0]  off_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  rd_reg;

    logic        wb_valid_reg;
    logic        wb_regwrite_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic [1:0]  wb_exc_reg;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        accept;
    logic        legal_f3;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [3:0][7:0] wdata_lanes;
    logic [31:0] wdata_next;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;
    logic        timed_out;
    logic [15:0] cnt_next;

    assign is_load  = (bus.ex_opcode == OP_LOAD);
    assign is_store = (bus.ex_opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign accept   = bus.ex_valid && (state_reg == S_IDLE);

    // Unsigned byte/half sizes exist only for loads.
    always_comb begin
        legal_f3 = 1'b0;
        case (bus.ex_funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = is_load;
            default:                legal_f3 = 1'b0;
        endcase
    end

    assign misaligned = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_alu_result[0]) ||
                        ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_alu_result[1:0] != 2'b00));

    always_comb begin
        be_next = 4'b1111;
        case (bus.ex_funct3[1:0])
            2'b00:   be_next = 4'b0001 << bus.ex_alu_result[1:0];
            2'b01:   be_next = bus.ex_alu_result[1] ? 4'b1100 : 4'b0011;
            default: be_next = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lanes[gi] =
                (bus.ex_funct3[1:0] == 2'b00) ? bus.ex_rd2[7:0] :
                (bus.ex_funct3[1:0] == 2'b01) ? bus.ex_rd2[8*(gi%2) +: 8] :
                                                bus.ex_rd2[8*gi +: 8];
        end
    endgenerate
    assign wdata_next = wdata_lanes;

    assign rdata_shifted = bus.mem_rdata >> {off_reg, 3'b000};

    always_comb begin
        load_data = bus.mem_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Abort on the ACK_TIMEOUT-th unacknowledged REQ cycle.
    assign timed_out = ({1'b0, cnt_reg} + 17'd1) >= TIMEOUT_LIMIT;
    assign cnt_next  = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= 16'd0;
            addr_reg        <= 32'd0;
            wdata_reg       <= 32'd0;
            be_reg          <= 4'd0;
            we_reg          <= 1'b0;
            off_reg         <= 2'd0;
            funct3_reg      <= 3'd0;
            rd_reg          <= 5'd0;
            wb_valid_reg    <= 1'b0;
            wb_regwrite_reg <= 1'b0;
            wb_rd_reg       <= 5'd0;
            wb_data_reg     <= 32'd0;
            wb_exc_reg      <= 2'b00;
        end else begin
            wb_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid_reg    <= 1'b1;
                            wb_regwrite_reg <= 1'b1;
                            wb_rd_reg       <= bus.ex_rd;
                            wb_data_reg     <= bus.ex_alu_result;
                            wb_exc_reg      <= 2'b00;
                        end else if (!legal_f3) begin
                            wb_valid_reg    <= 1'b1;
                            wb_regwrite_reg <= 1'b0;
                            wb_rd_reg       <= bus.ex_rd;
                            wb_data_reg     <= 32'd0;
                            wb_exc_reg      <= 2'b11;
                        end else if (misaligned) begin
                            wb_valid_reg    <= 1'b1;
                            wb_regwrite_reg <= 1'b0;
                            wb_rd_reg       <= bus.ex_rd;
                            wb_data_reg     <= bus.ex_alu_result;
                            wb_exc_reg      <= 2'b01;
                        end else begin
                            state_reg  <= S_REQ;
                            cnt_reg    <= 16'd0;
                            addr_reg   <= {bus.ex_alu_result[31:2], 2'b00};
                            off_reg    <= bus.ex_alu_result[1:0];
                            be_reg     <= be_next;
                            wdata_reg  <= is_store ? wdata_next : 32'd0;
                            we_reg     <= is_store;
                            funct3_reg <= bus.ex_funct3;
                            rd_reg     <= bus.ex_rd;
                        end
                    end
                end
                default: begin
                    if (bus.mem_ack) begin
                        state_reg       <= S_IDLE;
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= !we_reg;
                        wb_rd_reg       <= rd_reg;
                        wb_data_reg     <= we_reg ? 32'd0 : load_data;
                        wb_exc_reg      <= 2'b00;
                    end else if (timed_out) begin
                        state_reg       <= S_IDLE;
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= 1'b0;
                        wb_rd_reg       <= rd_reg;
                        wb_data_reg     <= 32'd0;
                        wb_exc_reg      <= 2'b10;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
            endcase
        end
    end

    assign bus.ex_ready    = (state_reg == S_IDLE);
    assign bus.mem_req     = (state_reg == S_REQ);
    assign bus.mem_we      = we_reg;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_be      = be_reg;
    assign bus.mem_wdata   = wdata_reg;
    assign bus.wb_valid    = wb_valid_reg;
    assign bus.wb_regwrite = wb_regwrite_reg;
    assign bus.wb_rd       = wb_rd_reg;
    assign bus.wb_data     = wb_data_reg;
    assign bus.wb_exc      = wb_exc_reg;
endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: expected writebacks (with their arrival cycle) are queued
// as stimulus is driven and popped by a negedge monitor.
module tb_lsu_stage;
    localparam int unsigned TMO      = 4;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_stage_if bus();

    lsu_stage #(.ACK_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic [1:0]  exc;
        int unsigned cyc;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                             input logic chk_data, input logic [1:0] exc, input int unsigned at);
        wb_exp_t e;
        e.rw = rw; e.rd = rd; e.data = data; e.chk_data = chk_data; e.exc = exc; e.cyc = at;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            $display("wb: rd=%0d data=%h regwrite=%b exc=%b cycle=%0d",
                     bus.wb_rd, bus.wb_data, bus.wb_regwrite, bus.wb_exc, cyc);
            if (sb_q.size() == 0) begin
                check_val("wb_unexpected", {31'b0, bus.wb_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("wb_cycle", cyc, mon_e.cyc);
                check_val("wb_exc", {30'b0, bus.wb_exc}, {30'b0, mon_e.exc});
                check_val("wb_regwrite", {31'b0, bus.wb_regwrite}, {31'b0, mon_e.rw});
                if (mon_e.rw) check_val("wb_rd", {27'b0, bus.wb_rd}, {27'b0, mon_e.rd});
                if (mon_e.chk_data) check_val("wb_data", bus.wb_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one op; the accept edge is the next posedge, returned as its cycle number.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] rd, output int unsigned acc);
        int n = 0;
        while (bus.ex_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check_val("ex_ready_before_issue", {31'b0, bus.ex_ready}, 32'd1);
        bus.ex_valid      = 1'b1;
        bus.ex_opcode     = op;
        bus.ex_funct3     = f3;
        bus.ex_alu_result = alu;
        bus.ex_rd2        = rd2;
        bus.ex_rd         = rd;
        acc = cyc + 1;
    endtask

    task automatic mem_op(input logic [2:0] f3, input logic store, input logic [31:0] addr,
                          input logic [31:0] rd2, input logic [4:0] rd, input logic [31:0] rdata,
                          input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        int unsigned acc;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        issue(store ? OP_STORE : OP_LOAD, f3, addr, rd2, rd, acc);
        step();
        bus.ex_valid = 1'b0;
        check_val("mem_req_first_cycle", cyc, acc);
        for (int i = 0; i <= waits; i++) begin
            check_val("mem_req", {31'b0, bus.mem_req}, 32'd1);
            check_val("mem_addr", bus.mem_addr, exp_addr);
            check_val("mem_be", {28'b0, bus.mem_be}, {28'b0, exp_be});
            check_val("mem_wdata", bus.mem_wdata, exp_wdata);
            check_val("mem_we", {31'b0, bus.mem_we}, {31'b0, store});
            check_val("ex_ready_in_req", {31'b0, bus.ex_ready}, 32'd0);
            if (i == waits) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                expect_wb(!store, rd, store ? 32'd0 : exp_wb, 1'b1, 2'b00, cyc + 1);
            end
            step();
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        check_val("mem_req_after_ack", {31'b0, bus.mem_req}, 32'd0);
        check_val("ex_ready_after_ack", {31'b0, bus.ex_ready}, 32'd1);
        step();
    endtask

    initial begin
        int unsigned acc;
        int hi;
        int n;
        bus.ex_valid      = 1'b0;
        bus.ex_opcode     = 7'd0;
        bus.ex_funct3     = 3'd0;
        bus.ex_alu_result = 32'd0;
        bus.ex_rd2        = 32'd0;
        bus.ex_rd         = 5'd0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 32'd0;

        repeat (3) step();
        check_val("rst_ex_ready", {31'b0, bus.ex_ready}, 32'd1);
        check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check_val("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        check_val("rst_wb_data", bus.wb_data, 32'd0);
        check_val("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back non-memory ops.
        for (int k = 1; k <= 3; k++) begin
            issue(OP_ALU, 3'b000, 32'(k), 32'hFFFF_FFFF, 5'(4 + k), acc);
            expect_wb(1'b1, 5'(4 + k), 32'(k), 1'b1, 2'b00, acc);
            step();
        end
        bus.ex_valid = 1'b0;
        repeat (2) step();

        mem_op(3'b000, 1'b0, 32'h0000_1003, 32'h5555_5555, 5'd10, 32'h80FF_FF00, 0,
               4'b1000, 32'd0, 32'hFFFF_FF80);
        mem_op(3'b100, 1'b0, 32'h0000_1003, 32'h5555_5555, 5'd11, 32'h80FF_FF00, 0,
               4'b1000, 32'd0, 32'h0000_0080);
        mem_op(3'b001, 1'b0, 32'h0000_1002, 32'd0, 5'd12, 32'h8001_7FFF, 1,
               4'b1100, 32'd0, 32'hFFFF_8001);
        mem_op(3'b101, 1'b0, 32'h0000_1000, 32'd0, 5'd13, 32'h8001_F00D, 0,
               4'b0011, 32'd0, 32'h0000_F00D);
        mem_op(3'b010, 1'b0, 32'h0000_1004, 32'd0, 5'd14, 32'h1234_5678, 2,
               4'b1111, 32'd0, 32'h1234_5678);
        mem_op(3'b001, 1'b1, 32'h0000_2002, 32'h1234_ABCD, 5'd15, 32'd0, 3,
               4'b1100, 32'hABCD_ABCD, 32'd0);
        mem_op(3'b000, 1'b1, 32'h0000_5001, 32'h0000_00AB, 5'd16, 32'd0, 0,
               4'b0010, 32'hABAB_ABAB, 32'd0);

        // Misaligned word load, misaligned half store, illegal sizes.
        issue(OP_LOAD, 3'b010, 32'h0000_3001, 32'd0, 5'd3, acc);
        expect_wb(1'b0, 5'd3, 32'h0000_3001, 1'b1, 2'b01, acc);
        step();
        bus.ex_valid = 1'b0;
        check_val("misaligned_no_req", {31'b0, bus.mem_req}, 32'd0);
        issue(OP_STORE, 3'b001, 32'h0000_2001, 32'd7, 5'd4, acc);
        expect_wb(1'b0, 5'd4, 32'h0000_2001, 1'b1, 2'b01, acc);
        step();
        issue(OP_LOAD, 3'b011, 32'h0000_3000, 32'd0, 5'd5, acc);
        expect_wb(1'b0, 5'd5, 32'd0, 1'b1, 2'b11, acc);
        step();
        issue(OP_STORE, 3'b110, 32'h0000_2003, 32'd0, 5'd6, acc);
        expect_wb(1'b0, 5'd6, 32'd0, 1'b1, 2'b11, acc);
        step();
        bus.ex_valid = 1'b0;
        check_val("illegal_no_req", {31'b0, bus.mem_req}, 32'd0);
        step();

        // Store with no ack: aborts after TMO request cycles.
        issue(OP_STORE, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd9, acc);
        expect_wb(1'b0, 5'd9, 32'd0, 1'b0, 2'b10, acc + TMO);
        step();
        bus.ex_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < int'(TMO) + 2; i++) begin
            if (bus.mem_req === 1'b1) hi++;
            step();
        end
        check_val("timeout_req_cycles", 32'(hi), 32'(TMO));

        // Stray ack while idle must not produce a writeback.
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();

        // Ack on the last allowed cycle beats the timeout.
        mem_op(3'b010, 1'b1, 32'h0000_4008, 32'hCAFE_F00D, 5'd17, 32'd0, int'(TMO) - 1,
               4'b1111, 32'hCAFE_F00D, 32'd0);

        // Reset in the middle of a request.
        issue(OP_LOAD, 3'b010, 32'h0000_6000, 32'd0, 5'd20, acc);
        step();
        bus.ex_valid = 1'b0;
        check_val("req_before_reset", {31'b0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_val("req_async_drop", {31'b0, bus.mem_req}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_val("ex_ready_after_reset", {31'b0, bus.ex_ready}, 32'd1);
        repeat (4) step();

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
